// File: rtl/mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer
//
// Operand sequencer for the 16-bit half-precision multiply/divide core. Takes
// one operation at a time from upstream, loads it into the core by holding the
// core in reset for one cycle with stable operands, waits for the core's done
// (or a timeout covering the core's silent exponent-overflow path), then
// presents a flag-qualified result downstream.
//
// Handshakes: both sides use valid/ready. A transfer happens on the rising
// edge where valid and ready are both high. A producer holds valid and its
// data stable until that edge. ready never depends combinationally on valid.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   in_valid/in_ready    upstream operation handshake
//   in_x, in_y, in_op    operands and op select (0 = multiply, 1 = divide)
//   core_x, core_y       operands to the core, stable from LOAD through HOLD
//   core_mulDiv          op select to the core
//   core_reset           registered reset to the core; high in IDLE and LOAD
//   core_done            core completion strobe, only looked at in RUN
//   core_result          raw core result
//   core_ofuf            core flags: 10 = overflow, 01 = underflow
//   out_valid/out_ready  downstream result handshake
//   out_result           cleaned-up half-precision result
//   out_ofuf             final flags
//   out_timeout          result came from the timeout path
//   dbg_state            current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 HOLD)
// -----------------------------------------------------------------------------
module mul_div_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic        in_op,
  output logic [15:0] core_x,
  output logic [15:0] core_y,
  output logic        core_mulDiv,
  output logic        core_reset,
  input  logic        core_done,
  input  logic [15:0] core_result,
  input  logic [1:0]  core_ofuf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [1:0]  out_ofuf,
  output logic        out_timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;

  logic        w_sign;
  logic [15:0] w_cap_result;
  logic [1:0]  w_cap_ofuf;
  logic        w_timeout_hit;

  assign dbg_state = r_state;

  // Sign of a product or quotient; used for the saturated infinity/zero.
  assign w_sign = core_x[15] ^ core_y[15];

  // r_cnt counts RUN cycles that ended without done. The timeout capture
  // happens on the RUN edge after TIMEOUT such cycles, which puts the
  // accept-to-valid latency at TIMEOUT+2.
  assign w_timeout_hit = (r_cnt == LP_TIMEOUT);

  // Flag cleanup: overflow (10, and 11 treated the same) saturates to signed
  // infinity, underflow saturates to signed zero.
  always_comb begin
    w_cap_result = core_result;
    w_cap_ofuf   = 2'b00;
    if (core_ofuf[1]) begin
      w_cap_result = {w_sign, 15'h7C00};
      w_cap_ofuf   = 2'b10;
    end else if (core_ofuf[0]) begin
      w_cap_result = {w_sign, 15'h0000};
      w_cap_ofuf   = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      in_ready    <= 1'b1;
      core_reset  <= 1'b1;
      core_x      <= 16'h0000;
      core_y      <= 16'h0000;
      core_mulDiv <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= 16'h0000;
      out_ofuf    <= 2'b00;
      out_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            core_x      <= in_x;
            core_y      <= in_y;
            core_mulDiv <= in_op;
            in_ready    <= 1'b0;
            r_state     <= S_LOAD;
          end
        end

        // Core is still in reset this cycle with the new operands stable; it
        // samples them on this edge. Releasing reset here also discards any
        // done left over from the previous operation.
        S_LOAD: begin
          r_cnt      <= 8'd0;
          core_reset <= 1'b0;
          r_state    <= S_RUN;
        end

        S_RUN: begin
          if (core_done) begin
            out_result  <= w_cap_result;
            out_ofuf    <= w_cap_ofuf;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            r_state     <= S_HOLD;
          end else if (w_timeout_hit) begin
            out_result  <= {w_sign, 15'h7C00};
            out_ofuf    <= 2'b10;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            core_reset <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_div_sequencer
//
// Bench for mul_div_sequencer with TIMEOUT = 8, driving a behavioural core
// stub whose done delay, result and flags are set per operation. Every
// operation's expected result, flags, timeout bit and accept-to-valid latency
// come from a small model of the sequencer's rules and go into exp_q. A single
// negedge compare process checks the handshake outputs, core-side outputs and
// result outputs on every cycle against that model. Each directed vector also
// carries a hand-computed literal that pins the model and the captured result.
// -----------------------------------------------------------------------------
module tb_mul_div_sequencer;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = 16'h0;
  logic [15:0] in_y = 16'h0;
  logic        in_op = 1'b0;
  logic [15:0] core_x, core_y;
  logic        core_mulDiv;
  logic        core_reset;
  logic        core_done = 1'b0;
  logic [15:0] core_result;
  logic [1:0]  core_ofuf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [1:0]  out_ofuf;
  logic        out_timeout;
  logic [1:0]  dbg_state;

  mul_div_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_op(in_op),
    .core_x(core_x), .core_y(core_y), .core_mulDiv(core_mulDiv),
    .core_reset(core_reset), .core_done(core_done),
    .core_result(core_result), .core_ofuf(core_ofuf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ofuf(out_ofuf), .out_timeout(out_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- core stub ----------------
  // done rises registered D cycles after reset release; D = 0 never finishes.
  int          stub_d = 0;
  int          stub_cnt = 0;
  logic [15:0] stub_result = 16'h0;
  logic [1:0]  stub_flags = 2'b00;

  assign core_result = stub_result;
  assign core_ofuf   = stub_flags;

  always @(posedge clk) begin
    if (core_reset) begin
      stub_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (stub_d != 0 && stub_cnt + 1 == stub_d) core_done <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {latency[7:0], timeout, ofuf[1:0], result[15:0]}
  logic [26:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input int d, input logic [15:0] res,
                                        input logic [1:0] fl);
    logic        s;
    logic [15:0] r;
    logic [1:0]  f;
    logic        t;
    int          lat;
    s = x[15] ^ y[15];
    if (d >= 1 && d <= TO) begin
      // done wins, including on the same edge as the timeout
      lat = d + 2;
      t   = 1'b0;
      if (fl == 2'b00)     begin r = res;              f = 2'b00; end
      else if (fl[1])      begin r = {s, 15'h7C00};    f = 2'b10; end
      else                 begin r = {s, 15'h0000};    f = 2'b01; end
    end else begin
      lat = TO + 2;
      t   = 1'b1;
      r   = {s, 15'h7C00};
      f   = 2'b10;
    end
    return {8'(lat), t, f, r};
  endfunction

  // ---------------- compare process ----------------
  logic        in_flight = 1'b0;
  int          acc_edge = 0;
  int          pop_edge = 0;
  logic        b2b = 1'b0;
  logic [15:0] fx, fy;
  logic        fop;
  logic [15:0] last_res = 16'h0;
  logic [1:0]  last_ofuf = 2'b0;
  logic        last_to = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_core_reset", core_reset, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      in_flight = 1'b0;
      exp_q.delete();
    end else begin
      chk("ready_valid_exclusive", in_ready & out_valid, 0);
      if (in_flight && exp_q.size() > 0) begin
        int elapsed;
        logic exp_ov;
        elapsed = cyc - acc_edge;
        exp_ov  = (elapsed >= int'(exp_q[0][26:19]));
        chk("core_x_stable", core_x, fx);
        chk("core_y_stable", core_y, fy);
        chk("core_mulDiv_stable", core_mulDiv, fop);
        chk("in_ready_busy", in_ready, 0);
        chk("core_reset_phase", core_reset, (elapsed == 0) ? 1 : 0);
        chk("out_valid_timing", out_valid, exp_ov);
        if (out_valid) begin
          chk("out_fields", {out_timeout, out_ofuf, out_result}, exp_q[0][18:0]);
          if (out_ready) begin
            last_res  = out_result;
            last_ofuf = out_ofuf;
            last_to   = out_timeout;
            pop_edge  = cyc + 1;
            void'(exp_q.pop_front());
            in_flight = 1'b0;
          end
        end else if (elapsed > int'(exp_q[0][26:19]) + 20) begin
          chk("result_never_arrived", out_valid, 1);
          void'(exp_q.pop_front());
          in_flight = 1'b0;
        end
      end else begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_core_reset", core_reset, 1);
        chk("idle_in_ready", in_ready, 1);
      end
      if (in_valid && in_ready) begin
        if (b2b) chk("b2b_accept_gap", (cyc + 1) - pop_edge, 1);
        in_flight = 1'b1;
        acc_edge  = cyc + 1;
        fx  = in_x;
        fy  = in_y;
        fop = in_op;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves in_valid high.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic op,
                          input int d, input logic [15:0] res, input logic [1:0] fl,
                          input logic [26:0] lit);
    logic [26:0] e;
    stub_d      = d;
    stub_result = res;
    stub_flags  = fl;
    e = model(x, y, d, res, fl);
    chk("model_pin", e, lit);
    exp_q.push_back(e);
    in_x = x;
    in_y = y;
    in_op = op;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) chk("accept_seen", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic check_lit(input string tag, input logic [26:0] lit);
    chk({tag, "_result"}, last_res, lit[15:0]);
    chk({tag, "_ofuf"}, last_ofuf, lit[17:16]);
    chk({tag, "_timeout"}, last_to, lit[18]);
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic op, input int d, input logic [15:0] res,
                        input logic [1:0] fl, input logic [26:0] lit);
    @(posedge clk);
    #1 start_op(x, y, op, d, res, fl, lit);
    wait_accept();
    wait_out();
    @(posedge clk);
    #1 check_lit(tag, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_result", out_result, 16'h0000);
    chk("rst_out_ofuf", out_ofuf, 2'b00);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_core_x", core_x, 16'h0000);
    chk("rst_core_y", core_y, 16'h0000);
    chk("rst_core_mulDiv", core_mulDiv, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    //       tag          x         y         op  D  stub res  fl     {lat, to, ofuf, result}
    run_op("mul_basic",  16'h3C00, 16'h4000, 0,  1, 16'h4000, 2'b00, {8'd3,  1'b0, 2'b00, 16'h4000});
    run_op("div_ovf",    16'hC000, 16'h0000, 1,  3, 16'h1234, 2'b10, {8'd5,  1'b0, 2'b10, 16'hFC00});
    run_op("mul_unf",    16'h0400, 16'h0400, 0,  2, 16'h5555, 2'b01, {8'd4,  1'b0, 2'b01, 16'h0000});
    run_op("timeout",    16'h7800, 16'h7800, 0,  0, 16'h0101, 2'b00, {8'd10, 1'b1, 2'b10, 16'h7C00});
    run_op("flags11",    16'hBC00, 16'h3C00, 0,  4, 16'h1111, 2'b11, {8'd6,  1'b0, 2'b10, 16'hFC00});
    run_op("neg_unf",    16'h8400, 16'h0400, 0,  2, 16'h2222, 2'b01, {8'd4,  1'b0, 2'b01, 16'h8000});
    run_op("done_at_to", 16'h3800, 16'h4000, 1,  8, 16'h3E00, 2'b00, {8'd10, 1'b0, 2'b00, 16'h3E00});
    run_op("to_neg",     16'h4000, 16'hC000, 0,  9, 16'h3333, 2'b01, {8'd10, 1'b1, 2'b10, 16'hFC00});

    // Result held 5 cycles with the next operation already pending.
    out_ready = 1'b0;
    @(posedge clk);
    #1 start_op(16'h4200, 16'h3800, 1, 2, 16'h4A00, 2'b00, {8'd4, 1'b0, 2'b00, 16'h4A00});
    wait_accept();
    wait_out();
    @(posedge clk);
    #1 start_op(16'h5000, 16'h5000, 0, 1, 16'h7BFF, 2'b00, {8'd3, 1'b0, 2'b00, 16'h7BFF});
    b2b = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    check_lit("hold_a", {8'd4, 1'b0, 2'b00, 16'h4A00});
    b2b = 1'b0;
    wait_out();
    @(posedge clk);
    #1 check_lit("hold_b", {8'd3, 1'b0, 2'b00, 16'h7BFF});

    // Reset in the middle of RUN aborts with no output.
    @(posedge clk);
    #1 start_op(16'h3C00, 16'h3C00, 0, 10, 16'h3C00, 2'b00, {8'd10, 1'b1, 2'b10, 16'h7C00});
    wait_accept();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_core_reset", core_reset, 1);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_release_in_ready", in_ready, 1);
    repeat (15) @(negedge clk);

    // Normal operation resumes after the abort.
    run_op("after_rst",  16'h3C00, 16'hBC00, 0,  1, 16'hBC00, 2'b00, {8'd3,  1'b0, 2'b00, 16'hBC00});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
